// File: rtl/fp_exec_unit.sv
// fp_exec_unit: multi-cycle single-precision FP execute stage (ADD/SUB/MUL/MOV/NEG/ABS)
// feeding the FP register-file write port. Optional sticky exception flags: FP_EXEC_FLAGS_EN.
module fp_exec_unit #(
  parameter int          MUL_ITERS = 24,
  parameter logic [31:0] NAN_CANON = 32'h7FC0_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [4:0]  destIn,
  output logic        busy,
  output logic        regWrite,
  output logic [4:0]  regDest,
  output logic [31:0] writeData
`ifdef FP_EXEC_FLAGS_EN
  ,
  input  logic        clrFlags,
  output logic [2:0]  flags
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_MUL, S_NORM, S_WB
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_MOV = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_ABS = 3'b101;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        dest_q, dest_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [23:0]       ma_q, ma_d, mb_q, mb_d;
  logic              sb_q, sb_d, sign_q, sign_d, nan_q, nan_d;
  logic signed [9:0] exp_q, exp_d;
  logic [47:0]       mant_q, mant_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [31:0]       res_q, res_d;

  // Field decode of the captured operands; exponent-0 operands lose their mantissa.
  logic        sa, sb, za, ia, ib;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;

  assign sa = a_q[31];
  assign sb = b_q[31];
  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  assign za = (ea == 8'd0);
  assign ia = (ea == 8'hFF);
  assign ib = (eb == 8'hFF);
  assign ma = za ? 24'd0 : {1'b1, a_q[22:0]};
  assign mb = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};

  // Working mantissa is 2.46 fixed point: bit 46 weighs 1.0 at exponent exp_q.
  function automatic logic [5:0] lead_zeros(input logic [47:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd0;
    found = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(47 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic [5:0]        lz;
  logic [47:0]       norm;
  logic [23:0]       top;
  logic signed [9:0] exp_n;
  logic              nonzero, is_ovf, is_unf;
  logic [31:0]       norm_res;

  always_comb begin
    lz      = lead_zeros(mant_q);
    norm    = mant_q << lz;
    top     = 24'(norm >> 24);
    exp_n   = exp_q + 10'sd1 - $signed({4'd0, lz});
    nonzero = top[23];
    is_ovf  = !nan_q && nonzero && (exp_n >= 10'sd255);
    is_unf  = !nan_q && nonzero && (exp_n <= 10'sd0);
    if (nan_q)                norm_res = NAN_CANON;
    else if (!nonzero || is_unf) norm_res = {sign_q, 31'd0};
    else if (is_ovf)          norm_res = {sign_q, 8'hFF, 23'd0};
    else                      norm_res = {sign_q, exp_n[7:0], top[22:0]};
  end

  logic [7:0]  diff;
  logic [4:0]  shamt;
  logic [24:0] sum, step;
  logic        sum_sign;
  logic [31:0] unary;

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dest_d   = dest_q;
    a_d      = a_q;
    b_d      = b_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    sb_d     = sb_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    cnt_d    = cnt_q;
    nan_d    = nan_q;
    res_d    = res_q;
    diff     = 8'd0;
    shamt    = 5'd0;
    sum      = 25'd0;
    step     = 25'd0;
    sum_sign = 1'b0;
    unary    = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = opA;
          b_d     = opB;
          dest_d  = destIn;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        nan_d = 1'b0;
        case (op_q)
          OP_MOV, OP_NEG, OP_ABS: begin
            unary = za ? {sa, 31'd0} : a_q;
            if (op_q == OP_NEG)      unary[31] = ~unary[31];
            else if (op_q == OP_ABS) unary[31] = 1'b0;
            res_d   = unary;
            state_d = S_WB;
          end
          OP_ADD, OP_SUB: begin
            nan_d   = ia | ib;
            state_d = S_ALIGN;
          end
          OP_MUL: begin
            nan_d   = ia | ib;
            sign_d  = sa ^ sb;
            exp_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
            mant_d  = 48'd0;
            ma_d    = ma;
            mb_d    = mb;
            cnt_d   = 5'd0;
            state_d = S_MUL;
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_ALIGN: begin
        sb_d = sb ^ (op_q == OP_SUB);
        if (ea >= eb) begin
          diff  = ea - eb;
          shamt = (diff > 8'd31) ? 5'd31 : diff[4:0];
          exp_d = $signed({2'b00, ea});
          ma_d  = ma;
          mb_d  = mb >> shamt;
        end else begin
          diff  = eb - ea;
          shamt = (diff > 8'd31) ? 5'd31 : diff[4:0];
          exp_d = $signed({2'b00, eb});
          ma_d  = ma >> shamt;
          mb_d  = mb;
        end
        state_d = S_ADD;
      end

      S_ADD: begin
        if (sa == sb_q) begin
          sum      = {1'b0, ma_q} + {1'b0, mb_q};
          sum_sign = sa;
        end else if (ma_q >= mb_q) begin
          sum      = {1'b0, ma_q} - {1'b0, mb_q};
          sum_sign = sa;
        end else begin
          sum      = {1'b0, mb_q} - {1'b0, ma_q};
          sum_sign = sb_q;
        end
        sign_d  = (sum == 25'd0) ? 1'b0 : sum_sign;
        mant_d  = {sum, 23'd0};
        state_d = S_NORM;
      end

      // Right-shifting shift-add: one multiplier bit per cycle, product builds from the top.
      S_MUL: begin
        step   = {1'b0, mant_q[47:24]} + {1'b0, (mb_q[0] ? ma_q : 24'd0)};
        mant_d = {step, mant_q[23:1]};
        mb_d   = mb_q >> 1;
        if (cnt_q == 5'(MUL_ITERS - 1)) begin
          cnt_d   = 5'd0;
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_NORM: begin
        res_d   = norm_res;
        state_d = S_WB;
      end

      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      dest_q  <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      ma_q    <= 24'd0;
      mb_q    <= 24'd0;
      sb_q    <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= 10'sd0;
      mant_q  <= 48'd0;
      cnt_q   <= 5'd0;
      nan_q   <= 1'b0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sb_q    <= sb_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      cnt_q   <= cnt_d;
      nan_q   <= nan_d;
      res_q   <= res_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign regWrite  = (state_q == S_WB);
  assign regDest   = dest_q;
  assign writeData = res_q;

`ifdef FP_EXEC_FLAGS_EN
  // Events are staged in NORM (cleared in UNPACK for unary ops) and folded in during WB.
  logic [2:0] evt_q, evt_d, flags_q, flags_d;

  always_comb begin
    evt_d = evt_q;
    if (state_q == S_UNPACK)    evt_d = 3'b000;
    else if (state_q == S_NORM) evt_d = {nan_q, is_ovf, is_unf};
    flags_d = clrFlags ? 3'b000 : flags_q;
    if (state_q == S_WB) flags_d = flags_d | evt_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      evt_q   <= 3'b000;
      flags_q <= 3'b000;
    end else begin
      evt_q   <= evt_d;
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_exec_unit.sv
// Directed bench for fp_exec_unit: expected writes are queued at issue and matched on regWrite.
module tb_fp_exec_unit;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_MOV = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_ABS = 3'b101;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] opA = 32'd0;
  logic [31:0] opB = 32'd0;
  logic [4:0]  destIn = 5'd0;
  logic        busy, regWrite;
  logic [4:0]  regDest;
  logic [31:0] writeData;
`ifdef FP_EXEC_FLAGS_EN
  logic        clrFlags = 1'b0;
  logic [2:0]  flags;
`endif

  fp_exec_unit dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .opA       (opA),
    .opB       (opB),
    .destIn    (destIn),
    .busy      (busy),
    .regWrite  (regWrite),
    .regDest   (regDest),
    .writeData (writeData)
`ifdef FP_EXEC_FLAGS_EN
    ,
    .clrFlags  (clrFlags),
    .flags     (flags)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_cmp    = 0;
  int  n_fail   = 0;
  int  n_writes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Register-file side: the write is sampled on the falling edge, as the file commits it.
  always @(negedge clock) begin
    wb_t e;
    if (regWrite) begin
      n_writes++;
      check("wb_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wb_dest", 32'(regDest), 32'(e.dest));
        check("wb_data", writeData, e.data);
      end
    end
  end

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic [31:0] res,
                        input int lat, input int poke_at);
    int cyc;
    int w0;
    @(negedge clock);
    start  = 1'b1;
    op     = o;
    opA    = a;
    opB    = b;
    destIn = d;
    exp_q.push_back('{dest: d, data: res});
    w0 = n_writes;
    @(posedge clock); #1;
    start  = 1'b0;
    op     = 3'($urandom);
    opA    = $urandom;
    opB    = $urandom;
    destIn = 5'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == poke_at) begin
        start  = 1'b1;
        op     = OP_ADD;
        opA    = 32'h3F80_0000;
        destIn = 5'd31;
      end else begin
        start = 1'b0;
      end
      if (regWrite) break;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(lat));
    @(posedge clock); #1;
    check({tag, "_strobe_len"}, 32'(regWrite), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clock);
    check({tag, "_writes"}, 32'(n_writes - w0), 32'd1);
  endtask

  initial begin
    int w0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_regWrite", 32'(regWrite), 32'd0);
    check("rst_regDest", 32'(regDest), 32'd0);
    check("rst_writeData", writeData, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run_op("add_1p2",   OP_ADD, 32'h3F80_0000, 32'h4000_0000, 5'd5,  32'h4040_0000, 4, 0);
    run_op("sub_zero",  OP_SUB, 32'h3FC0_0000, 32'h3FC0_0000, 5'd6,  32'h0000_0000, 4, 0);
    run_op("sub_3m1",   OP_SUB, 32'h4040_0000, 32'h3F80_0000, 5'd7,  32'h4000_0000, 4, 0);
    run_op("sub_neg",   OP_SUB, 32'h3F80_0000, 32'h4040_0000, 5'd8,  32'hC000_0000, 4, 0);
    run_op("sub_lshift", OP_SUB, 32'h3F80_0000, 32'h3F7F_FFFF, 5'd9, 32'h3400_0000, 4, 0);
    run_op("mul_3xm2",  OP_MUL, 32'h4040_0000, 32'hC000_0000, 5'd10, 32'hC0C0_0000, 26, 10);
    run_op("neg",       OP_NEG, 32'h3F80_0000, 32'h3F80_0000, 5'd11, 32'hBF80_0000, 1, 0);
    run_op("abs",       OP_ABS, 32'hC000_0000, 32'hC000_0000, 5'd12, 32'h4000_0000, 1, 0);
    run_op("mov_nan",   OP_MOV, 32'h7F81_2345, 32'h7F81_2345, 5'd13, 32'h7F81_2345, 1, 0);
    run_op("neg_nan",   OP_NEG, 32'h7F81_2345, 32'h7F81_2345, 5'd14, 32'hFF81_2345, 1, 0);

    @(negedge clock);
    start = 1'b1;
    op    = 3'b110;
    opA   = 32'h3F80_0000;
    opB   = 32'h3F80_0000;
    w0    = n_writes;
    @(posedge clock); #1;
    start = 1'b0;
    check("illegal_busy_start", 32'(busy), 32'd1);
    repeat (2) @(posedge clock);
    #1;
    check("illegal_busy_drop", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    check("illegal_writes", 32'(n_writes - w0), 32'd0);

`ifdef FP_EXEC_FLAGS_EN
    check("flags_clean", 32'(flags), 32'd0);
`endif
    run_op("mul_ovf",   OP_MUL, 32'h7F00_0000, 32'h4000_0000, 5'd15, 32'h7F80_0000, 26, 0);
    run_op("add_nan",   OP_ADD, 32'h7FC0_0000, 32'h3F80_0000, 5'd16, 32'h7FC0_0000, 4, 0);
`ifdef FP_EXEC_FLAGS_EN
    check("flags_set", 32'(flags), 32'b110);
    @(negedge clock);
    clrFlags = 1'b1;
    @(posedge clock); #1;
    clrFlags = 1'b0;
    check("flags_clear", 32'(flags), 32'd0);
`endif

    run_op("mul_unf",   OP_MUL, 32'h0080_0000, 32'h0080_0000, 5'd17, 32'h0000_0000, 26, 0);
`ifdef FP_EXEC_FLAGS_EN
    check("flags_unf", 32'(flags), 32'b001);
`endif
    run_op("mul_nzero", OP_MUL, 32'h8000_0000, 32'h3F80_0000, 5'd18, 32'h8000_0000, 26, 0);
    run_op("mul_infz",  OP_MUL, 32'h7F80_0000, 32'h0000_0000, 5'd19, 32'h7FC0_0000, 26, 0);
    run_op("add_denorm", OP_ADD, 32'h0000_0001, 32'h3F80_0000, 5'd20, 32'h3F80_0000, 4, 0);
    run_op("add_shift24", OP_ADD, 32'h4B80_0000, 32'h3F80_0000, 5'd21, 32'h4B80_0000, 4, 0);
    run_op("add_satshift", OP_ADD, 32'h7E80_0000, 32'h3F80_0000, 5'd22, 32'h7E80_0000, 4, 0);
    run_op("add_ovf",   OP_ADD, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'd23, 32'h7F80_0000, 4, 0);

    @(negedge clock);
    start  = 1'b1;
    op     = OP_MUL;
    opA    = 32'h4040_0000;
    opB    = 32'hC000_0000;
    destIn = 5'd3;
    w0     = n_writes;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_regWrite", 32'(regWrite), 32'd0);
    check("midrst_writeData", writeData, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    check("midrst_writes", 32'(n_writes - w0), 32'd0);
    run_op("add_after_rst", OP_ADD, 32'h3F80_0000, 32'h4000_0000, 5'd5, 32'h4040_0000, 4, 0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
